// File: rtl/srt_divider.sv
// Radix-2 SRT unsigned divider: 8-bit dividend / 6-bit divisor, fixed 10-cycle latency.
// Redundant quotient (QP/QN digit vectors) resolved and corrected in the final cycle.
module srt_divider (
    input  logic       clk,
    input  logic       resetn,
    input  logic       enable,
    input  logic [7:0] N,
    input  logic [5:0] D,
    output logic [9:0] Q,
    output logic [7:0] R
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_NORM = 2'd1;
    localparam logic [1:0] S_ITER = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [7:0]         dvd_q, dvd_d;
    logic [5:0]         dvs_q, dvs_d;
    logic [2:0]         s_q, s_d;
    logic signed [15:0] p_q, p_d;
    logic signed [15:0] dal_q, dal_d;
    logic [7:0]         qp_q, qp_d;
    logic [7:0]         qn_q, qn_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [9:0]         q_q, q_d;
    logic [7:0]         r_q, r_d;

    logic [2:0]         lz;
    logic [5:0]         dn;
    logic signed [15:0] p2;
    logic signed [15:0] half;
    logic signed [15:0] p_fix;
    logic [9:0]         qb;
    logic [3:0]         shamt;

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        s_d     = s_q;
        p_d     = p_q;
        dal_d   = dal_q;
        qp_d    = qp_q;
        qn_d    = qn_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;

        // Leading-zero count: the highest set bit is visited last and wins.
        lz = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (dvs_q[i]) lz = 3'(5 - i);
        end
        dn = dvs_q << lz;

        p2   = p_q <<< 1;
        half = dal_q >>> 1;

        // Resolve the redundant quotient; a negative final P means one step too many.
        qb    = {2'b00, qp_q} - {2'b00, qn_q};
        p_fix = p_q;
        if (p_q[15]) begin
            qb    = qb - 10'd1;
            p_fix = p_q + dal_q;
        end
        shamt = 4'd8 + {1'b0, s_q};

        case (state_q)
            S_IDLE: begin
                if (enable == 1'b1) begin
                    dvd_d   = N;
                    dvs_d   = D;
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                // Dividend is pre-shifted by s as well, so 8 iterations yield N/D directly.
                s_d     = lz;
                dal_d   = signed'({2'b00, dn, 8'h00});
                p_d     = signed'({8'h00, dvd_q} << lz);
                qp_d    = 8'h00;
                qn_d    = 8'h00;
                cnt_d   = 3'd7;
                state_d = S_ITER;
            end
            S_ITER: begin
                if (p2 >= half) begin
                    p_d  = p2 - dal_q;
                    qp_d = {qp_q[6:0], 1'b1};
                    qn_d = {qn_q[6:0], 1'b0};
                end else if (p2 < -half) begin
                    p_d  = p2 + dal_q;
                    qp_d = {qp_q[6:0], 1'b0};
                    qn_d = {qn_q[6:0], 1'b1};
                end else begin
                    p_d  = p2;
                    qp_d = {qp_q[6:0], 1'b0};
                    qn_d = {qn_q[6:0], 1'b0};
                end
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd0) state_d = S_FIX;
            end
            default: begin
                if (dvs_q == 6'd0) begin
                    q_d = 10'h3FF;
                    r_d = dvd_q;
                end else begin
                    q_d = qb;
                    r_d = 8'(p_fix >> shamt);
                end
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q <= S_IDLE;
            dvd_q   <= 8'h00;
            dvs_q   <= 6'h00;
            s_q     <= 3'd0;
            p_q     <= 16'sd0;
            dal_q   <= 16'sd0;
            qp_q    <= 8'h00;
            qn_q    <= 8'h00;
            cnt_q   <= 3'd0;
            q_q     <= 10'h000;
            r_q     <= 8'h00;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            s_q     <= s_d;
            p_q     <= p_d;
            dal_q   <= dal_d;
            qp_q    <= qp_d;
            qn_q    <= qn_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
        end
    end

    assign Q = q_q;
    assign R = r_q;

endmodule

// File: tb/tb_srt_divider.sv
// Directed and randomized checks of srt_divider against a floor/mod reference model.
module tb_srt_divider;

    logic       clk = 1'b0;
    logic       resetn;
    logic       enable;
    logic [7:0] N;
    logic [5:0] D;
    logic [9:0] Q;
    logic [7:0] R;

    int checks = 0;
    int errors = 0;

    logic [9:0] last_q;
    logic [7:0] last_r;

    srt_divider dut (
        .clk    (clk),
        .resetn (resetn),
        .enable (enable),
        .N      (N),
        .D      (D),
        .Q      (Q),
        .R      (R)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] model_q(input logic [7:0] n, input logic [5:0] d);
        int ni, di;
        ni = int'(n);
        di = int'(d);
        if (di == 0) return 10'h3FF;
        return 10'(ni / di);
    endfunction

    function automatic logic [7:0] model_r(input logic [7:0] n, input logic [5:0] d);
        int ni, di;
        ni = int'(n);
        di = int'(d);
        if (di == 0) return n;
        return 8'(ni % di);
    endfunction

    // One isolated operation; when 'disturb' is set, inputs churn while busy.
    task automatic do_op(input logic [7:0] n, input logic [5:0] d, input string tag, input bit disturb);
        logic [9:0] eq;
        logic [7:0] er;
        eq = model_q(n, d);
        er = model_r(n, d);
        @(negedge clk);
        N = n; D = d; enable = 1'b1;
        @(posedge clk);
        #1 enable = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            if (disturb) begin
                @(negedge clk);
                N = 8'($urandom);
                D = 6'($urandom);
                enable = (c < 9) ? 1'($urandom) : 1'b0;
            end
            @(posedge clk);
        end
        #1;
        chk({tag, "_hold_q"}, 32'(Q), 32'(last_q));
        chk({tag, "_hold_r"}, 32'(R), 32'(last_r));
        @(posedge clk);
        #1;
        chk({tag, "_q"}, 32'(Q), 32'(eq));
        chk({tag, "_r"}, 32'(R), 32'(er));
        $display("op %s N=%02h D=%02h -> Q=%03h R=%02h (want %03h %02h)", tag, n, d, Q, R, eq, er);
        last_q = eq;
        last_r = er;
    endtask

    initial begin
        logic [7:0] rn;
        logic [5:0] rd;
        resetn = 1'b1; enable = 1'b0; N = 8'h00; D = 6'h00;
        last_q = 10'h000; last_r = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_q", 32'(Q), 32'h0);
        chk("reset_r", 32'(R), 32'h0);
        @(negedge clk);
        resetn = 1'b0;

        do_op(8'h40, 6'h10, "d40_10", 1'b0);
        do_op(8'h70, 6'h3F, "d70_3f", 1'b0);
        do_op(8'hFF, 6'h01, "dff_01", 1'b0);
        do_op(8'h05, 6'h3F, "d05_3f", 1'b0);
        do_op(8'h00, 6'h07, "d00_07", 1'b0);
        do_op(8'h9A, 6'h00, "d9a_00", 1'b0);
        do_op(8'hFF, 6'h3F, "dff_3f", 1'b0);
        do_op(8'hC8, 6'h0D, "disturb", 1'b1);

        // Reset in the middle of an operation: outputs clear and no late write appears.
        @(negedge clk);
        N = 8'hC8; D = 6'h0D; enable = 1'b1;
        @(posedge clk);
        #1 enable = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset_q", 32'(Q), 32'h0);
        chk("midreset_r", 32'(R), 32'h0);
        @(negedge clk);
        resetn = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("nowrite_q", 32'(Q), 32'h0);
        chk("nowrite_r", 32'(R), 32'h0);
        last_q = 10'h000; last_r = 8'h00;
        do_op(8'h64, 6'h07, "after_rst", 1'b0);

        // Back-to-back with enable held high: one capture every 11 cycles.
        for (int k = 0; k < 300; k++) begin
            rn = 8'($urandom);
            case (k % 6)
                0: rd = 6'h01;
                1: rd = 6'h3F;
                2: rd = 6'h00;
                default: rd = 6'($urandom_range(1, 63));
            endcase
            if (k % 10 == 3) rn = 8'hFF;
            if (k % 10 == 7) rn = 8'h00;
            @(negedge clk);
            N = rn; D = rd; enable = 1'b1;
            @(posedge clk);
            repeat (10) @(posedge clk);
            #1;
            chk("b2b_q", 32'(Q), 32'(model_q(rn, rd)));
            chk("b2b_r", 32'(R), 32'(model_r(rn, rd)));
            $display("b2b %0d N=%02h D=%02h -> Q=%03h R=%02h", k, rn, rd, Q, R);
        end
        enable = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
